// File: rtl/sfp_act_unit.sv
// Handshaked fixed-point activation unit: Step/ReLU and saturated Sigmoid/Tanh
// on a fast path; otherwise exp via Taylor series and a shared restoring divider.
module sfp_act_unit #(
  parameter int WIDTH     = 64,
  parameter int FRAC      = 32,
  parameter int EXP_TERMS = 50,
  parameter int SIG_SAT   = 15,
  parameter int TANH_SAT  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat
);

  localparam int CW = $clog2(WIDTH);
  localparam int IW = $clog2(EXP_TERMS) + 1;

  localparam logic signed [WIDTH-1:0] ONE      = WIDTH'(1) << FRAC;
  localparam logic signed [WIDTH-1:0] NEG_ONE  = -ONE;
  localparam logic signed [WIDTH-1:0] TWO      = ONE << 1;
  localparam logic signed [WIDTH-1:0] SIG_LIM  = WIDTH'(SIG_SAT) << FRAC;
  localparam logic signed [WIDTH-1:0] SIG_NEG  = -SIG_LIM;
  localparam logic signed [WIDTH-1:0] TANH_LIM = WIDTH'(TANH_SAT) << FRAC;
  localparam logic signed [WIDTH-1:0] TANH_NEG = -TANH_LIM;
  localparam logic signed [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] M_STEP = 2'd0;
  localparam logic [1:0] M_SIG  = 2'd1;
  localparam logic [1:0] M_TANH = 2'd2;
  localparam logic [1:0] M_RELU = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_RECIP, S_FIN, S_DONE} state_t;

  state_t state, state_nx;

  logic                    loaded;
  logic signed [WIDTH-1:0] x_r;
  logic [1:0]              mode_r;
  logic signed [WIDTH-1:0] result, term, arg;
  logic [IW-1:0]           idx;

  logic [WIDTH-1:0]        rem, dlo, quo, dvs;
  logic                    q_neg, d_zero, a_neg;
  logic [CW-1:0]           cnt;

  logic                    fast;
  logic signed [WIDTH-1:0] fast_val;
  logic signed [2*WIDTH-1:0] term_x, arg_x, prod;
  logic signed [WIDTH-1:0] mul_res;
  logic [WIDTH:0]          r2;
  logic                    ge;
  logic [WIDTH-1:0]        diff, quo_nx, rem_nx;
  logic signed [WIDTH-1:0] q_signed, sum_nx;
  logic                    cnt_last, last_term, div_load;
  logic signed [WIDTH-1:0] ld_a, ld_d;
  logic [WIDTH-1:0]        ld_amag, ld_dmag;

  assign cnt_last  = (cnt == CW'(WIDTH - 1));
  assign last_term = (idx == IW'(EXP_TERMS - 1));

  always_comb begin
    fast     = 1'b0;
    fast_val = '0;
    case (mode_r)
      M_STEP: begin
        fast     = 1'b1;
        fast_val = x_r[WIDTH-1] ? '0 : ONE;
      end
      M_RELU: begin
        fast     = 1'b1;
        fast_val = (!x_r[WIDTH-1] && x_r != '0) ? x_r : '0;
      end
      M_SIG: begin
        if (x_r > SIG_LIM) begin
          fast     = 1'b1;
          fast_val = ONE;
        end else if (x_r < SIG_NEG) begin
          fast     = 1'b1;
          fast_val = '0;
        end
      end
      default: begin
        if (x_r > TANH_LIM) begin
          fast     = 1'b1;
          fast_val = ONE;
        end else if (x_r < TANH_NEG) begin
          fast     = 1'b1;
          fast_val = NEG_ONE;
        end
      end
    endcase
  end

  assign term_x  = {{WIDTH{term[WIDTH-1]}}, term};
  assign arg_x   = {{WIDTH{arg[WIDTH-1]}}, arg};
  assign prod    = term_x * arg_x;
  assign mul_res = WIDTH'(prod >>> FRAC);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign r2       = {rem, dlo[WIDTH-1]};
  assign ge       = (r2 >= {1'b0, dvs});
  assign diff     = r2[WIDTH-1:0] - dvs;
  assign rem_nx   = ge ? diff : r2[WIDTH-1:0];
  assign quo_nx   = {quo[WIDTH-2:0], ge};
  assign q_signed = d_zero ? (a_neg ? MIN_NEG : MAX_POS)
                           : (q_neg ? -quo_nx : quo_nx);
  assign sum_nx   = result + q_signed;

  // The divider is reloaded either from the fresh product (series step) or,
  // after the final term, with the reciprocal operands using the new sum.
  assign div_load = (state == S_MUL) || (state == S_DIV && cnt_last && last_term);
  assign ld_a     = (state == S_MUL) ? mul_res : ((mode_r == M_SIG) ? ONE : TWO);
  assign ld_d     = (state == S_MUL) ? (WIDTH'(idx) << FRAC) : (ONE + sum_nx);
  assign ld_amag  = ld_a[WIDTH-1] ? -ld_a : ld_a;
  assign ld_dmag  = ld_d[WIDTH-1] ? -ld_d : ld_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (loaded) state_nx = fast ? S_DONE : S_MUL;
      S_MUL:   state_nx = S_DIV;
      S_DIV:   if (cnt_last) state_nx = last_term ? S_RECIP : S_MUL;
      S_RECIP: if (cnt_last) state_nx = S_FIN;
      S_FIN:   state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      loaded    <= 1'b0;
      x_r       <= '0;
      mode_r    <= '0;
      result    <= '0;
      term      <= '0;
      arg       <= '0;
      idx       <= '0;
      rem       <= '0;
      dlo       <= '0;
      quo       <= '0;
      dvs       <= '0;
      q_neg     <= 1'b0;
      d_zero    <= 1'b0;
      a_neg     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (loaded) begin
            loaded <= 1'b0;
            if (fast) begin
              out_data  <= fast_val;
              out_sat   <= 1'b1;
              out_valid <= 1'b1;
            end else begin
              result <= ONE;
              term   <= ONE;
              idx    <= IW'(1);
              arg    <= (mode_r == M_SIG) ? -x_r : -(x_r <<< 1);
            end
          end else if (in_ready && in_valid) begin
            x_r      <= in_data;
            mode_r   <= in_mode;
            loaded   <= 1'b1;
            in_ready <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_MUL: term <= mul_res;
        S_DIV, S_RECIP: begin
          rem <= rem_nx;
          dlo <= dlo << 1;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt_last) begin
            term <= q_signed;
            if (state == S_DIV) begin
              result <= sum_nx;
              idx    <= idx + 1'b1;
            end
          end
        end
        S_FIN: begin
          out_data  <= (mode_r == M_SIG) ? term : term - ONE;
          out_sat   <= 1'b0;
          out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase

      if (div_load) begin
        rem    <= ld_amag >> (WIDTH - FRAC);
        dlo    <= ld_amag << FRAC;
        quo    <= '0;
        dvs    <= ld_dmag;
        q_neg  <= ld_a[WIDTH-1] ^ ld_d[WIDTH-1];
        d_zero <= (ld_d == '0);
        a_neg  <= ld_a[WIDTH-1];
        cnt    <= '0;
      end
    end
  end

endmodule
